spi_regbank_slave: RTL and testbench



---
 rtl/spi_regbank_slave.sv | 194 +++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_slave.sv
// SPI slave bridging a host CPU to a flat register bank: burst reads from RD_DATA,
// burst writes as WR_ADDR/WR_DATA/WR_STB pulses, all SPI pins resynchronised into SYS_CLK.
module spi_regbank_slave #(
    parameter int                  DATA_W   = 16,
    parameter int                  NUM_REGS = 64,
    parameter int                  ADDR_W   = 10,
    parameter int                  SPI_MODE = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [31:0]         ID_WORD  = 32'h0000_4A53
) (
    input  logic                         SYS_CLK,
    input  logic                         RST_N,
    input  logic                         SPI_CLK,
    input  logic                         SSEL,
    input  logic                         MOSI,
    output logic                         MISO,
    input  logic [NUM_REGS*DATA_W-1:0]   RD_DATA,
    output logic [ADDR_W-1:0]            WR_ADDR,
    output logic [DATA_W-1:0]            WR_DATA,
    output logic                         WR_STB,
    output logic                         BUSY,
    output logic                         FRAME_ERR
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam bit CPOL  = ((SPI_MODE / 2) % 2) != 0;
    localparam bit CPHA  = (SPI_MODE % 2) != 0;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_READ, ST_WRITE} state_t;
    state_t state, state_nxt;

    logic [2:0]        sck_q, ssel_q, mosi_q;
    logic [1:0]        settle_cnt;
    logic              resync;
    logic [DATA_W-1:0] shreg, word_q, rx_word, rd_word;
    logic [DATA_W-2:0] rx_sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic              fresh, rd_pend, wr_pend, wr_ok;
    logic              sck_new, sck_old, lead_edge, trail_edge, sample_edge, shift_edge;
    logic              ssel_fall, ssel_rise, word_cplt;
    logic [1:0]        op;

    // After reset, a falling SSEL is only trusted once SSEL has been seen idle, so a
    // frame interrupted by reset is ignored until the host starts a new one.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            sck_q      <= '0;
            ssel_q     <= 3'b111;
            mosi_q     <= '0;
            settle_cnt <= '0;
            resync     <= 1'b1;
        end else begin
            sck_q  <= {sck_q[1:0], SPI_CLK};
            ssel_q <= {ssel_q[1:0], SSEL};
            mosi_q <= {mosi_q[1:0], MOSI};
            if (settle_cnt != 2'd3)
                settle_cnt <= settle_cnt + 2'd1;
            if (resync && settle_cnt == 2'd3 && ssel_q[2] && ssel_q[1])
                resync <= 1'b0;
        end
    end

    assign sck_new     = sck_q[1] ^ CPOL;
    assign sck_old     = sck_q[2] ^ CPOL;
    assign lead_edge   = !sck_old && sck_new;
    assign trail_edge  = sck_old && !sck_new;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ssel_fall   = ssel_q[2] && !ssel_q[1] && !resync;
    assign ssel_rise   = !ssel_q[2] && ssel_q[1];
    assign rx_word     = {rx_sr, mosi_q[2]};
    assign op          = rx_word[DATA_W-1:DATA_W-2];
    assign word_cplt   = (state != ST_IDLE) && !ssel_rise && sample_edge &&
                         (bit_cnt == CNT_W'(DATA_W-1));

    always_comb begin
        rd_word = '0;
        wr_ok   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_word = RD_DATA[i*DATA_W +: DATA_W];
                wr_ok   = !RO_MASK[i];
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ssel_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (ssel_rise)
                    state_nxt = ST_IDLE;
                else if (word_cplt && op == 2'b10)
                    state_nxt = ST_READ;
                else if (word_cplt && op == 2'b01)
                    state_nxt = ST_WRITE;
            end
            ST_READ, ST_WRITE: if (ssel_rise) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        MISO = (state != ST_IDLE) && shreg[DATA_W-1];
    end

    // WR_STB is a single-cycle pulse; WR_ADDR/WR_DATA are valid in that cycle and
    // hold afterwards. There is no backpressure: the register side must accept it.
    // A freshly loaded word sets 'fresh' so the next shift edge presents its MSb
    // instead of shifting it away.
    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            shreg     <= '0;
            fresh     <= 1'b0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            word_q    <= '0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= '0;
            WR_STB    <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            WR_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            BUSY      <= !ssel_q[1];
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
                if (ssel_fall) begin
                    shreg <= ID_WORD[DATA_W-1:0];
                    fresh <= CPHA;
                end
            end else if (ssel_rise) begin
                bit_cnt   <= '0;
                FRAME_ERR <= (bit_cnt != '0);
            end else begin
                if (sample_edge) begin
                    rx_sr <= rx_word[DATA_W-2:0];
                    if (word_cplt) begin
                        bit_cnt <= '0;
                        word_q  <= rx_word;
                        fresh   <= 1'b1;
                        if (!(state == ST_READ || (state == ST_CMD && op == 2'b10)))
                            shreg <= '0;
                        case (state)
                            ST_CMD: begin
                                if (op == 2'b10 || op == 2'b01)
                                    addr <= rx_word[ADDR_W-1:0];
                                rd_pend <= (op == 2'b10);
                            end
                            ST_READ:  rd_pend <= 1'b1;
                            ST_WRITE: wr_pend <= 1'b1;
                            default:  ;
                        endcase
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (shift_edge) begin
                    if (fresh)
                        fresh <= 1'b0;
                    else
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
                end
            end
            if (rd_pend && state == ST_READ) begin
                shreg <= rd_word;
                fresh <= 1'b1;
                addr  <= addr + ADDR_W'(1);
            end
            if (wr_pend) begin
                if (wr_ok) begin
                    WR_ADDR <= addr;
                    WR_DATA <= word_q;
                    WR_STB  <= 1'b1;
                end
                addr <= addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave: one instance per SPI mode sharing SCK/MOSI,
// each selected by its own SSEL; register 3 is read-only in every instance.
module tb_spi_regbank_slave;
    localparam int DW   = 16;
    localparam int NR   = 64;
    localparam int AW   = 10;
    localparam int HALF = 80;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sck;
    logic [3:0]       ssel;
    logic             mosi;
    logic [NR*DW-1:0] rd_data;
    logic [3:0]       miso, wr_stb, busy, frame_err;
    logic [AW-1:0]    wr_addr [4];
    logic [DW-1:0]    wr_data [4];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_regbank_slave #(
            .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .SPI_MODE(m),
            .RO_MASK(64'h8), .ID_WORD(32'h0000_4A53)
        ) u_dut (
            .SYS_CLK(clk), .RST_N(rst_n), .SPI_CLK(sck), .SSEL(ssel[m]), .MOSI(mosi),
            .MISO(miso[m]), .RD_DATA(rd_data), .WR_ADDR(wr_addr[m]), .WR_DATA(wr_data[m]),
            .WR_STB(wr_stb[m]), .BUSY(busy[m]), .FRAME_ERR(frame_err[m])
        );
    end

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int other_stb = 0;
    int fe0;
    logic [DW-1:0]    exp_q [$];
    logic [AW+DW-1:0] stb_q [$];
    logic [DW-1:0]    rx;

    // Strobe / frame-error log, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_stb[0] === 1'b1) stb_q.push_back({wr_addr[0], wr_data[0]});
        if (frame_err[0] === 1'b1) fe_cnt++;
        if (wr_stb[3:1] != 3'b000) other_stb++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int mode, input logic [DW-1:0] tx, input int nbits,
                        output logic [DW-1:0] rxw);
        logic cpol, cpha;
        cpol = ((mode >> 1) & 1) != 0;
        cpha = (mode & 1) != 0;
        rxw  = '0;
        for (int i = DW-1; i >= DW-nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                #HALF;
                rxw[i] = miso[mode];
                sck = ~cpol;
                #HALF;
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = tx[i];
                #HALF;
                rxw[i] = miso[mode];
                sck = cpol;
                #HALF;
            end
        end
    endtask

    task automatic xfer_chk(input int mode, input logic [DW-1:0] tx, input string tag);
        logic [DW-1:0] r, e;
        xfer(mode, tx, DW, r);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check(tag, r, e);
    endtask

    task automatic start_frame(input int mode);
        sck = ((mode >> 1) & 1) != 0;
        repeat (4) @(negedge clk);
        ssel[mode] = 1'b0;
        #100;
    endtask

    task automatic end_frame(input int mode);
        #HALF;
        ssel[mode] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        ssel  = 4'hF;
        mosi  = 1'b0;
        for (int i = 0; i < NR; i++) rd_data[i*DW +: DW] = {8'(i), ~8'(i)};
        rd_data[0 +: DW]  = 16'hA5A5;
        rd_data[DW +: DW] = 16'h5A5A;

        repeat (5) @(negedge clk);
        check("rst_miso", miso[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_wr_stb", wr_stb[0], 0);
        check("rst_frame_err", frame_err[0], 0);
        check("rst_wr_addr", wr_addr[0], 0);
        check("rst_wr_data", wr_data[0], 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", busy[0], 0);

        // Burst read of reg5..reg7 in mode 0
        exp_q.push_back(16'h4A53); exp_q.push_back(16'h05FA);
        exp_q.push_back(16'h06F9); exp_q.push_back(16'h07F8);
        start_frame(0);
        check("frame_busy", busy[0], 1);
        xfer_chk(0, 16'h8005, "rd_id");
        xfer_chk(0, 16'h0000, "rd_reg5");
        xfer_chk(0, 16'h0000, "rd_reg6");
        xfer_chk(0, 16'h0000, "rd_reg7");
        end_frame(0);
        check("rd_no_stb", stb_q.size(), 0);
        check("end_busy", busy[0], 0);

        // Burst write at 25
        exp_q.push_back(16'h4A53);
        start_frame(0);
        xfer_chk(0, 16'h4019, "wr_id");
        xfer(0, 16'h1234, DW, rx);
        xfer(0, 16'hABCD, DW, rx);
        end_frame(0);
        check("wr_stb_count", stb_q.size(), 2);
        if (stb_q.size() == 2) begin
            check("wr_stb0", stb_q.pop_front(), {10'd25, 16'h1234});
            check("wr_stb1", stb_q.pop_front(), {10'd26, 16'hABCD});
        end
        stb_q.delete();

        // Write burst across read-only reg3
        start_frame(0);
        xfer(0, 16'h4002, DW, rx);
        xfer(0, 16'h0001, DW, rx);
        xfer(0, 16'h0002, DW, rx);
        xfer(0, 16'h0003, DW, rx);
        end_frame(0);
        check("ro_stb_count", stb_q.size(), 2);
        if (stb_q.size() == 2) begin
            check("ro_stb0", stb_q.pop_front(), {10'd2, 16'h0001});
            check("ro_stb1", stb_q.pop_front(), {10'd4, 16'h0003});
        end
        stb_q.delete();

        // SSEL released 9 bits into the second write word
        fe0 = fe_cnt;
        start_frame(0);
        xfer(0, 16'h400A, DW, rx);
        xfer(0, 16'h1111, DW, rx);
        xfer(0, 16'h2222, 9, rx);
        end_frame(0);
        check("fe_stb_count", stb_q.size(), 1);
        if (stb_q.size() == 1) check("fe_stb0", stb_q.pop_front(), {10'd10, 16'h1111});
        check("fe_pulses", fe_cnt - fe0, 1);
        stb_q.delete();
        exp_q.push_back(16'h4A53); exp_q.push_back(16'h05FA);
        start_frame(0);
        xfer_chk(0, 16'h8005, "after_fe_id");
        xfer_chk(0, 16'h0000, "after_fe_reg5");
        end_frame(0);

        // Patterned read in every mode
        for (int m = 0; m < 4; m++) begin
            exp_q.push_back(16'h4A53); exp_q.push_back(16'hA5A5); exp_q.push_back(16'h5A5A);
            start_frame(m);
            xfer_chk(m, 16'h8000, $sformatf("mode%0d_id", m));
            xfer_chk(m, 16'h0000, $sformatf("mode%0d_reg0", m));
            xfer_chk(m, 16'h0000, $sformatf("mode%0d_reg1", m));
            end_frame(m);
        end
        check("mode_no_stb", other_stb, 0);

        // Read past the top of the bank
        exp_q.push_back(16'h4A53); exp_q.push_back(16'h3FC0);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        start_frame(0);
        xfer_chk(0, 16'h803F, "oor_id");
        xfer_chk(0, 16'h0000, "oor_reg63");
        xfer_chk(0, 16'h0000, "oor_reg64");
        xfer_chk(0, 16'h0000, "oor_reg65");
        end_frame(0);

        // Reset in the middle of a burst; rest of the frame must be ignored
        stb_q.delete();
        fe0 = fe_cnt;
        exp_q.push_back(16'h4A53);
        start_frame(0);
        xfer_chk(0, 16'h8005, "mid_rst_id");
        xfer(0, 16'h0000, 8, rx);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_miso", miso[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_wr_addr", wr_addr[0], 0);
        check("mid_rst_wr_data", wr_data[0], 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        xfer(0, 16'h0000, 8, rx);
        check("post_rst_tail_miso", rx, 0);
        xfer(0, 16'h4003, DW, rx);
        check("post_rst_cmd_miso", rx, 0);
        xfer(0, 16'h5555, DW, rx);
        end_frame(0);
        check("post_rst_no_stb", stb_q.size(), 0);
        check("post_rst_no_fe", fe_cnt - fe0, 0);
        exp_q.push_back(16'h4A53); exp_q.push_back(16'h05FA);
        start_frame(0);
        xfer_chk(0, 16'h8005, "fresh_id");
        xfer_chk(0, 16'h0000, "fresh_reg5");
        end_frame(0);
        start_frame(0);
        xfer(0, 16'h4007, DW, rx);
        xfer(0, 16'h00FF, DW, rx);
        end_frame(0);
        check("fresh_wr_count", stb_q.size(), 1);
        if (stb_q.size() == 1) check("fresh_wr_stb", stb_q.pop_front(), {10'd7, 16'h00FF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
